// File: rtl/vga_timing_gen.sv
// Purpose : raster timing generator (pixel strobe, h/v position, sync/blank levels, event pulses).
// Latency : one clk_i from the strobe edge to timing_o/x_o/y_o; first valid CLK_DIV edges after release.
// Backpressure: none; free-running while en_i=1, en_i=0 holds the generator in its reset state.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   en_i         1: run, 0: synchronously return to the reset state
//   timing_o     VGA_Timing struct (valid, levels, single-cycle pulses)
//   x_o, y_o     position of the pixel described by timing_o
//   frame_cnt_o  completed frames; counts only when VTG_FRAME_CNT_EN is defined, else tied to 0
//
// Build option: define VTG_FRAME_CNT_EN to enable the frame counter.

package vga_timing_pkg;
  typedef struct packed {
    logic valid;
    logic blank_n;
    logic hsync_n;
    logic vsync_n;
    logic end_of_line;
    logic end_of_visible_line;
    logic next_line_visible;
    logic end_of_frame;
  } VGA_Timing;
endpackage

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int SYNC_POS  = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output VGA_Timing   timing_o,
  output logic [10:0] x_o,
  output logic [10:0] y_o,
  output logic [15:0] frame_cnt_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Bounds are 12 bits wide so an end-exclusive bound of 2048 still fits.
  localparam logic [11:0] H_VIS   = 12'(H_VISIBLE);
  localparam logic [11:0] H_VIS_L = 12'(H_VISIBLE - 1);
  localparam logic [11:0] HS_BEG  = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END  = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_VIS   = 12'(V_VISIBLE);
  localparam logic [11:0] VS_BEG  = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_END  = 12'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);

  // Inactive pin level of the sync outputs.
  localparam logic SYNC_IDLE = (SYNC_POS == 0) ? 1'b1 : 1'b0;

  localparam VGA_Timing TIM_RST = '{
    valid: 1'b0, blank_n: 1'b0, hsync_n: SYNC_IDLE, vsync_n: SYNC_IDLE,
    end_of_line: 1'b0, end_of_visible_line: 1'b0, next_line_visible: 1'b0,
    end_of_frame: 1'b0
  };

  if (H_TOTAL > 2048 || V_TOTAL > 2048 || CLK_DIV < 1) begin : g_param_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 2048 and CLK_DIV >= 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d, v_next;
  VGA_Timing        tim_q, tim_d, pix;
  logic [11:0]      h_ext, v_ext;
  logic             strobe, h_last, v_last;

  always_comb begin
    h_ext  = {1'b0, h_q};
    v_ext  = {1'b0, v_q};
    strobe = (div_q == DIV_LAST);
    h_last = (h_ext == H_LAST);
    v_last = (v_ext == V_LAST);
    v_next = v_last ? 11'd0 : v_q + 11'd1;

    // Description of the pixel at the current (h,v).
    pix.valid               = 1'b1;
    pix.blank_n             = (h_ext < H_VIS) && (v_ext < V_VIS);
    pix.hsync_n             = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? ~SYNC_IDLE : SYNC_IDLE;
    pix.vsync_n             = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? ~SYNC_IDLE : SYNC_IDLE;
    pix.end_of_line         = h_last;
    pix.end_of_visible_line = (h_ext == H_VIS_L) && (v_ext < V_VIS);
    pix.next_line_visible   = ({1'b0, v_next} < V_VIS);
    pix.end_of_frame        = h_last && v_last;

    // Non-strobe edges: levels and position hold, valid and pulses drop.
    div_d                     = strobe ? '0 : div_q + DIV_W'(1);
    h_d                       = h_q;
    v_d                       = v_q;
    x_d                       = x_q;
    y_d                       = y_q;
    tim_d                     = tim_q;
    tim_d.valid               = 1'b0;
    tim_d.end_of_line         = 1'b0;
    tim_d.end_of_visible_line = 1'b0;
    tim_d.next_line_visible   = 1'b0;
    tim_d.end_of_frame        = 1'b0;

    if (strobe) begin
      tim_d = pix;
      x_d   = h_q;
      y_d   = v_q;
      h_d   = h_last ? 11'd0 : h_q + 11'd1;
      if (h_last) v_d = v_next;
    end

    // Disable always restarts from (0,0) with no partial line.
    if (!en_i) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
      x_d   = '0;
      y_d   = '0;
      tim_d = TIM_RST;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      tim_q <= TIM_RST;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      x_q   <= x_d;
      y_q   <= y_d;
      tim_q <= tim_d;
    end
  end

  assign timing_o = tim_q;
  assign x_o      = x_q;
  assign y_o      = y_q;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Increments on the same edge that registers end_of_frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= '0;
    end else if (en_i && strobe && pix.end_of_frame) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`else
  assign frame_cnt_o = 16'h0000;
`endif

endmodule
